// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types used by the memory-request sequencer
//
// Purpose : request sequencer state encoding and the CPU word type.
// Contents: CPU_WORD_W (datapath width), word_t, reqstate_t.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DREQ   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

endpackage

// File: rtl/link_register.sv
// rtl/link_register.sv - LL/SC link register with store and snoop invalidation
//
// Purpose : holds the load-linked reservation (valid flag + word address).
// Ports   : i_clk, i_rst_n       clock, async active-low reset
//           i_set                LL completed this cycle; reserve i_daddr_word
//           i_store_done         a store (SW/SC) completed this cycle at i_daddr_word
//           i_snoop_valid        external write observed at i_snoop_word
//           i_daddr_word         word address of the current data access
//           i_snoop_word         word address of the external write
//           o_link_valid         reservation currently held
//           o_match              reservation held and equal to i_daddr_word
module link_register
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = CPU_WORD_W - 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set,
    input  logic              i_store_done,
    input  logic              i_snoop_valid,
    input  logic [ADDR_W-1:0] i_daddr_word,
    input  logic [ADDR_W-1:0] i_snoop_word,
    output logic              o_link_valid,
    output logic              o_match
);

    logic              r_link_valid;
    logic [ADDR_W-1:0] r_link_addr;
    logic              w_snoop_old;
    logic              w_snoop_new;

    // Snoop against the reservation already held, and against the address
    // an LL is about to reserve in this very cycle.
    assign w_snoop_old = i_snoop_valid & (i_snoop_word == r_link_addr);
    assign w_snoop_new = i_snoop_valid & (i_snoop_word == i_daddr_word);

    assign o_match      = r_link_valid & (r_link_addr == i_daddr_word);
    assign o_link_valid = r_link_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (i_set) begin
            // A new reservation replaces the old one; a simultaneous external
            // write to the same word kills it before it is ever usable.
            r_link_valid <= ~w_snoop_new;
            r_link_addr  <= i_daddr_word;
        end else if ((i_store_done & o_match) | w_snoop_old) begin
            r_link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - memory-request sequencer with PC enable, sticky halt and LL/SC
//
// Purpose : turns per-instruction memory intent into registered memory
//           requests, generates pc_en, holds halt, decides SC success.
// Ports   : CLK, nRST              clock, async active-low reset
//           ihit, dhit             instruction / data access completed
//           dREN, dWEN             instruction reads / writes data memory
//           atomic, halt           instruction is LL/SC, instruction is HALT
//           daddr                  data address of current instruction
//           snoop_valid/_addr      external write observed
//           imemREN                instruction-memory read enable
//           dmemREN, dmemWEN       registered data request
//           pc_en                  instruction retires this cycle
//           halt_out               sticky halt
//           sc_result              SC outcome (valid when pc_en & atomic & dWEN)
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              atomic,
    input  logic              halt,
    input  logic [WORD_W-1:0] daddr,
    input  logic              snoop_valid,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              pc_en,
    output logic              halt_out,
    output logic              sc_result
);

    reqstate_t r_state;
    logic      r_dmemREN;
    logic      r_dmemWEN;
    logic      r_halt_out;

    logic      w_link_valid;
    logic      w_link_match;
    logic      w_sc_fail;
    logic      w_link_set;
    logic      w_store_done;
    logic      w_pc_en;
    logic      w_sc_result;

    // An SC without a live reservation on its word is resolved in the fetch
    // cycle: it retires with result 0 and never reaches memory.
    assign w_sc_fail    = ihit & dWEN & atomic & ~w_link_match;

    assign w_link_set   = (r_state == DREQ) & dhit & r_dmemREN & atomic;
    assign w_store_done = (r_state == DREQ) & dhit & r_dmemWEN;

    link_register #(
        .ADDR_W (WORD_W - 2)
    ) u_link (
        .i_clk         (CLK),
        .i_rst_n       (nRST),
        .i_set         (w_link_set),
        .i_store_done  (w_store_done),
        .i_snoop_valid (snoop_valid),
        .i_daddr_word  (daddr[WORD_W-1:2]),
        .i_snoop_word  (snoop_addr[WORD_W-1:2]),
        .o_link_valid  (w_link_valid),
        .o_match       (w_link_match)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_dmemREN  <= 1'b0;
            r_dmemWEN  <= 1'b0;
            r_halt_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ihit) begin
                        if (halt) begin
                            r_state    <= HALTED;
                            r_halt_out <= 1'b1;
                        end else if ((dREN | dWEN) & ~w_sc_fail) begin
                            r_state   <= DREQ;
                            r_dmemREN <= dREN;
                            r_dmemWEN <= dWEN;
                        end
                    end
                end
                DREQ: begin
                    if (dhit) begin
                        r_state   <= IDLE;
                        r_dmemREN <= 1'b0;
                        r_dmemWEN <= 1'b0;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Retirement: non-memory instructions and failed SCs retire in the fetch
    // cycle; memory instructions retire in their dhit cycle.
    always_comb begin
        w_pc_en     = 1'b0;
        w_sc_result = 1'b0;
        case (r_state)
            IDLE: begin
                if (ihit & ~halt) begin
                    if (w_sc_fail) begin
                        w_pc_en = 1'b1;
                    end else if (~(dREN | dWEN)) begin
                        w_pc_en = 1'b1;
                    end
                end
            end
            DREQ: begin
                w_pc_en     = dhit;
                w_sc_result = dhit & r_dmemWEN & atomic;
            end
            default: begin
                w_pc_en     = 1'b0;
                w_sc_result = 1'b0;
            end
        endcase
    end

    assign imemREN   = (r_state == IDLE);
    assign dmemREN   = r_dmemREN;
    assign dmemWEN   = r_dmemWEN;
    assign halt_out  = r_halt_out;
    assign pc_en     = w_pc_en;
    assign sc_result = w_sc_result;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - self-checking bench for request_unit
module tb_request_unit;

    localparam int WORD_W = 32;
    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_LL  = 3;
    localparam int K_SC  = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ihit, dhit, dREN, dWEN, atomic, halt, snoop_valid;
    logic [WORD_W-1:0] daddr, snoop_addr;
    logic              imemREN, dmemREN, dmemWEN, pc_en, halt_out, sc_result;

    int n_checks = 0;
    int n_pass   = 0;

    // Reservation as the program sees it.
    bit          m_link_valid = 1'b0;
    logic [29:0] m_link_word  = '0;

    always #5 CLK = ~CLK;

    request_unit #(.WORD_W(WORD_W)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .atomic      (atomic),
        .halt        (halt),
        .daddr       (daddr),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .pc_en       (pc_en),
        .halt_out    (halt_out),
        .sc_result   (sc_result)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] bases [4];
        bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200; bases[3] = 32'h204;
        return bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
    endfunction

    function automatic void model_snoop(input bit v, input logic [31:0] a);
        if (v && m_link_valid && a[31:2] == m_link_word) m_link_valid = 1'b0;
    endfunction

    task automatic clear_inputs();
        ihit = 0; dhit = 0; dREN = 0; dWEN = 0; atomic = 0; halt = 0;
        snoop_valid = 0; snoop_addr = '0; daddr = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic snoop_cycle(input logic [31:0] a);
        snoop_valid = 1; snoop_addr = a;
        @(negedge CLK);
        check_eq("snoop_idle_pc_en", pc_en, 0);
        model_snoop(1'b1, a);
        next_cycle();
        snoop_valid = 0;
    endtask

    // One instruction: idle gap, fetch cycle, optional data wait, dhit cycle.
    task automatic run_instr(input int kind, input logic [31:0] addr, input int gap,
                             input int lat, input bit snoop_dhit, input logic [31:0] snaddr,
                             input bit rnd);
        bit is_rd, is_wr, sc_ok, mem;
        for (int i = 0; i < gap; i++) begin
            ihit = 0;
            dhit = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            snoop_valid = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            snoop_addr = pick_addr();
            @(negedge CLK);
            check_eq("gap_pc_en", pc_en, 0);
            check_eq("gap_imemREN", imemREN, 1);
            check_eq("gap_dmemREN", dmemREN, 0);
            check_eq("gap_dmemWEN", dmemWEN, 0);
            model_snoop(snoop_valid, snoop_addr);
            next_cycle();
        end
        is_rd = (kind == K_LW) || (kind == K_LL);
        is_wr = (kind == K_SW) || (kind == K_SC);
        sc_ok = m_link_valid && (m_link_word == addr[31:2]);
        mem   = is_rd || (kind == K_SW) || ((kind == K_SC) && sc_ok);
        ihit = 1; dREN = is_rd; dWEN = is_wr;
        atomic = (kind == K_LL) || (kind == K_SC);
        daddr = addr; snoop_valid = 0;
        dhit = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge CLK);
        check_eq("fetch_imemREN", imemREN, 1);
        check_eq("fetch_dmemREN", dmemREN, 0);
        check_eq("fetch_dmemWEN", dmemWEN, 0);
        check_eq("fetch_pc_en", pc_en, !mem);
        if (kind == K_SC && !sc_ok) check_eq("sc_fail_result", sc_result, 0);
        next_cycle();
        ihit = 0; dhit = 0;
        if (mem) begin
            for (int j = 0; j < lat; j++) begin
                snoop_valid = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                snoop_addr = pick_addr();
                @(negedge CLK);
                check_eq("wait_dmemREN", dmemREN, is_rd);
                check_eq("wait_dmemWEN", dmemWEN, is_wr);
                check_eq("wait_imemREN", imemREN, 0);
                check_eq("wait_pc_en", pc_en, 0);
                model_snoop(snoop_valid, snoop_addr);
                next_cycle();
            end
            dhit = 1; snoop_valid = snoop_dhit; snoop_addr = snaddr;
            @(negedge CLK);
            check_eq("dhit_pc_en", pc_en, 1);
            check_eq("dhit_dmemREN", dmemREN, is_rd);
            check_eq("dhit_dmemWEN", dmemWEN, is_wr);
            check_eq("dhit_sc_result", sc_result, kind == K_SC);
            if (kind == K_LL) begin
                m_link_valid = !(snoop_dhit && snaddr[31:2] == addr[31:2]);
                m_link_word  = addr[31:2];
            end else begin
                if (is_wr && m_link_valid && m_link_word == addr[31:2]) m_link_valid = 1'b0;
                model_snoop(snoop_dhit, snaddr);
            end
            next_cycle();
        end
        clear_inputs();
        check_eq("link_valid", dut.w_link_valid, m_link_valid);
    endtask

    initial begin
        logic [31:0] a;
        int k;
        bit timed_out;
        clear_inputs();
        nRST = 0;
        repeat (2) @(negedge CLK);
        check_eq("rst_imemREN", imemREN, 1);
        check_eq("rst_pc_en", pc_en, 0);
        check_eq("rst_sc_result", sc_result, 0);
        check_eq("rst_dmemREN", dmemREN, 0);
        check_eq("rst_dmemWEN", dmemWEN, 0);
        check_eq("rst_halt_out", halt_out, 0);
        next_cycle();
        nRST = 1;

        // Directed scenarios.
        run_instr(K_LW, 32'h100, 0, 2, 0, 0, 0);
        run_instr(K_LL, 32'h200, 1, 1, 0, 0, 0);
        run_instr(K_SC, 32'h200, 0, 2, 0, 0, 0);
        run_instr(K_SC, 32'h200, 0, 0, 0, 0, 0);
        run_instr(K_LL, 32'h200, 0, 0, 0, 0, 0);
        snoop_cycle(32'h203);
        run_instr(K_SC, 32'h200, 0, 0, 0, 0, 0);
        run_instr(K_LL, 32'h204, 0, 1, 1, 32'h204, 0);
        run_instr(K_SC, 32'h204, 0, 0, 0, 0, 0);
        run_instr(K_LL, 32'h204, 0, 1, 1, 32'h100, 0);
        run_instr(K_SW, 32'h104, 0, 0, 0, 0, 0);
        run_instr(K_SC, 32'h206, 0, 1, 0, 0, 0);
        run_instr(K_ALU, 32'h0, 0, 0, 0, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 4);
            a = pick_addr();
            if (k == K_SC && m_link_valid && $urandom_range(0, 1) == 1)
                a = {m_link_word, 2'($urandom_range(0, 3))};
            run_instr(k, a, $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), pick_addr(), 1'b1);
        end

        // Halt is sticky until reset.
        ihit = 1; halt = 1;
        @(negedge CLK);
        check_eq("halt_cycle_pc_en", pc_en, 0);
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        check_eq("halt_out", halt_out, 1);
        check_eq("halt_imemREN", imemREN, 0);
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            ihit = 1'($urandom_range(0, 1)); dREN = 1'($urandom_range(0, 1));
            dWEN = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check_eq("halted_pc_en", pc_en, 0);
            check_eq("halted_dmemREN", dmemREN, 0);
            check_eq("halted_dmemWEN", dmemWEN, 0);
            check_eq("halted_imemREN", imemREN, 0);
            check_eq("halted_halt_out", halt_out, 1);
            next_cycle();
        end
        clear_inputs();
        nRST = 0;
        #1;
        check_eq("halt_rst_halt_out", halt_out, 0);
        check_eq("halt_rst_imemREN", imemREN, 1);
        next_cycle();
        nRST = 1;
        m_link_valid = 1'b0;
        run_instr(K_ALU, 32'h0, 0, 0, 0, 0, 0);

        // Reset while a store waits for dhit.
        ihit = 1; dWEN = 1; daddr = 32'h100;
        next_cycle();
        ihit = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (dmemWEN) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq("mid_dreq_wen_timeout", timed_out, 0);
        #1 nRST = 0;
        #1;
        check_eq("mid_dreq_rst_wen", dmemWEN, 0);
        check_eq("mid_dreq_rst_imem", imemREN, 1);
        check_eq("mid_dreq_rst_pc_en", pc_en, 0);
        next_cycle();
        clear_inputs();
        nRST = 1;
        m_link_valid = 1'b0;
        @(negedge CLK);
        check_eq("post_rst_imemREN", imemREN, 1);
        check_eq("post_rst_dmemWEN", dmemWEN, 0);
        next_cycle();
        run_instr(K_SW, 32'h104, 0, 1, 0, 0, 0);
        run_instr(K_ALU, 32'h0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
